// File: rtl/nrisc_pkg.sv
// Shared constants for the 8-bit nRISC multi-cycle core:
// opcodes, ALU encodings, FSM states and small decode helpers.
package nrisc_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_LD   = 4'h5;
  localparam logic [3:0] OP_ST   = 4'h6;
  localparam logic [3:0] OP_BEQ  = 4'h7;
  localparam logic [3:0] OP_JMP  = 4'h8;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;

  localparam logic [2:0] ST_FETCH  = 3'd0;
  localparam logic [2:0] ST_DECODE = 3'd1;
  localparam logic [2:0] ST_EXEC   = 3'd2;
  localparam logic [2:0] ST_MEM    = 3'd3;
  localparam logic [2:0] ST_WB     = 3'd4;
  localparam logic [2:0] ST_HALT   = 3'd5;

  function automatic logic op_illegal(
    input logic [3:0] op
  );
    return (op >= 4'h9) && (op <= 4'hE);
  endfunction

  function automatic logic [2:0] alu_op_of(
    input logic [3:0] op
  );
    logic [2:0] r;
    r = ALU_ADD;
    unique case (op)
      OP_SUB:  r = ALU_SUB;
      OP_AND:  r = ALU_AND;
      OP_OR:   r = ALU_OR;
      OP_BEQ:  r = ALU_SUB;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nrisc_mem_watchdog.sv
// Memory-access watchdog: counts unanswered request cycles
// and raises a sticky fault when the budget runs out.
module nrisc_mem_watchdog
  import nrisc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic req,
  input  logic ready,
  output logic expire,
  output logic fault
);

  localparam logic [3:0] LAST = 4'(WAIT_MAX - 1);

  logic [3:0] cnt_q, cnt_d;
  logic       fault_q, fault_d;
  logic       stall;

  // Ready on the final cycle still wins: stall requires !ready.
  always_comb begin
    stall   = req & ~ready;
    expire  = stall & (cnt_q == LAST);
    cnt_d   = cnt_q;
    if (clear) begin
      cnt_d = 4'd0;
    end else if (stall) begin
      cnt_d = cnt_q + 4'd1;
    end
    fault_d = fault_q | expire;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q   <= 4'd0;
      fault_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  assign fault = fault_q;

endmodule

// File: rtl/nrisc_multiciclo_ctrl.sv
// Multi-cycle control FSM for the nRISC datapath, with a
// req/ready memory handshake guarded by a watchdog.
module nrisc_multiciclo_ctrl
  import nrisc_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 15
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       mem_addr_sel,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       reg_write,
  output logic       wb_sel,
  output logic       alu_src_imm,
  output logic [2:0] alu_op,
  output logic       illegal,
  output logic       halted,
  output logic       bus_fault
);

  logic [2:0] state_q, state_d;
  logic in_fetch, in_dec, in_exec;
  logic in_mem, in_wb, in_halt;
  logic req, ack, wd_clear, wd_expire;
  logic is_ld, is_st, is_alu, br_take;

  always_comb begin
    in_fetch = (state_q == ST_FETCH);
    in_dec   = (state_q == ST_DECODE);
    in_exec  = (state_q == ST_EXEC);
    in_mem   = (state_q == ST_MEM);
    in_wb    = (state_q == ST_WB);
    in_halt  = (state_q == ST_HALT);
    // Gate with reset so an assertion drops req at once.
    req      = (in_fetch | in_mem) & reset_n;
    ack      = req & mem_ready;
    is_ld    = (opcode == OP_LD);
    is_st    = (opcode == OP_ST);
    is_alu   = (opcode <= OP_ADDI);
    br_take  = (opcode == OP_JMP)
             | ((opcode == OP_BEQ) & zero);
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_FETCH: begin
        if (ack) state_d = ST_DECODE;
        else if (wd_expire) state_d = ST_HALT;
      end
      ST_DECODE: begin
        if (op_illegal(opcode)) state_d = ST_FETCH;
        else if (opcode == OP_HALT) state_d = ST_HALT;
        else state_d = ST_EXEC;
      end
      ST_EXEC: begin
        if (is_alu) state_d = ST_WB;
        else if (is_ld | is_st) state_d = ST_MEM;
        else state_d = ST_FETCH;
      end
      ST_MEM: begin
        if (ack) state_d = is_st ? ST_FETCH : ST_WB;
        else if (wd_expire) state_d = ST_HALT;
      end
      ST_WB:   state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_FETCH;
    endcase
  end

  assign wd_clear = (state_d != state_q)
                  & ((state_d == ST_FETCH)
                  | (state_d == ST_MEM));

  nrisc_mem_watchdog #(
    .WAIT_MAX(WAIT_MAX)
  ) u_wd (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (wd_clear),
    .req    (req),
    .ready  (mem_ready),
    .expire (wd_expire),
    .fault  (bus_fault)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // ALU controls held through MEM/WB so its result stays stable.
  always_comb begin
    mem_req      = req;
    mem_addr_sel = in_mem & reset_n;
    mem_we       = in_mem & is_st & reset_n;
    ir_write     = in_fetch & ack;
    pc_src       = in_exec & br_take;
    pc_write     = (in_fetch & ack) | pc_src;
    reg_write    = in_wb;
    wb_sel       = in_wb & is_ld;
    alu_op       = ALU_ADD;
    alu_src_imm  = 1'b0;
    if (in_exec | in_mem | in_wb) begin
      alu_op      = alu_op_of(opcode);
      alu_src_imm = (opcode == OP_ADDI);
    end
    illegal      = in_dec & op_illegal(opcode);
    halted       = in_halt;
  end

endmodule

// File: tb/tb_nrisc_multiciclo_ctrl.sv
// Bench for nrisc_multiciclo_ctrl: table-driven instruction
// flows plus watchdog and reset sequences.
module tb_nrisc_multiciclo_ctrl;

  localparam logic [14:0] E_REQ = 15'h4000;
  localparam logic [14:0] E_WE  = 15'h2000;
  localparam logic [14:0] E_AS  = 15'h1000;
  localparam logic [14:0] E_PCW = 15'h0800;
  localparam logic [14:0] E_PCS = 15'h0400;
  localparam logic [14:0] E_IRW = 15'h0200;
  localparam logic [14:0] E_RW  = 15'h0100;
  localparam logic [14:0] E_WBS = 15'h0080;
  localparam logic [14:0] E_IMM = 15'h0040;
  localparam logic [14:0] E_SUB = 15'h0008;
  localparam logic [14:0] E_OR  = 15'h0018;
  localparam logic [14:0] E_ILL = 15'h0004;
  localparam logic [14:0] E_HLT = 15'h0002;
  localparam logic [14:0] E_BF  = 15'h0001;
  localparam logic [14:0] E_FOK = E_REQ | E_PCW | E_IRW;

  logic       clock;
  logic       reset_n;
  logic [3:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, mem_we, mem_addr_sel;
  logic       pc_write, pc_src, ir_write;
  logic       reg_write, wb_sel, alu_src_imm;
  logic [2:0] alu_op;
  logic       illegal, halted, bus_fault;
  logic [14:0] outs;

  typedef struct {
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [14:0] exp;
    string       nm;
  } vec_t;

  vec_t        tbl[$];
  logic [14:0] sb[$];
  int          n_pass;
  int          n_total;

  nrisc_multiciclo_ctrl #(.WAIT_MAX(15)) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .opcode      (opcode),
    .zero        (zero),
    .mem_ready   (mem_ready),
    .mem_req     (mem_req),
    .mem_we      (mem_we),
    .mem_addr_sel(mem_addr_sel),
    .pc_write    (pc_write),
    .pc_src      (pc_src),
    .ir_write    (ir_write),
    .reg_write   (reg_write),
    .wb_sel      (wb_sel),
    .alu_src_imm (alu_src_imm),
    .alu_op      (alu_op),
    .illegal     (illegal),
    .halted      (halted),
    .bus_fault   (bus_fault)
  );

  assign outs = {mem_req, mem_we, mem_addr_sel,
                 pc_write, pc_src, ir_write,
                 reg_write, wb_sel, alu_src_imm,
                 alu_op, illegal, halted, bus_fault};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string nm,
                       input logic [14:0] got,
                       input logic [14:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, got, exp);
  endtask

  task automatic add(input logic [3:0] op,
                     input logic z, input logic rdy,
                     input logic [14:0] exp,
                     input string nm);
    vec_t v;
    v.op = op; v.z = z; v.rdy = rdy;
    v.exp = exp; v.nm = nm;
    tbl.push_back(v);
  endtask

  // Called just after a rising edge; returns just after the next.
  task automatic cyc(input logic [3:0] op,
                     input logic z, input logic rdy,
                     input logic [14:0] exp,
                     input string nm);
    logic [14:0] e;
    opcode    = op;
    zero      = z;
    mem_ready = rdy;
    sb.push_back(exp);
    @(negedge clock);
    e = sb.pop_front();
    check(nm, outs, e);
    @(posedge clock);
    #1;
  endtask

  task automatic async_reset(input string nm);
    reset_n = 1'b0;
    #1;
    check(nm, outs, 15'h0000);
    @(negedge clock);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  initial begin
    n_pass    = 0;
    n_total   = 0;
    reset_n   = 1'b0;
    opcode    = 4'h0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    add(4'h4, 0, 1, E_FOK,          "addi_fetch");
    add(4'h4, 0, 0, 15'h0,          "addi_dec");
    add(4'h4, 0, 0, E_IMM,          "addi_exec");
    add(4'h4, 0, 0, E_RW | E_IMM,   "addi_wb");
    add(4'h5, 0, 1, E_FOK,          "ld_fetch");
    add(4'h5, 0, 0, 15'h0,          "ld_dec");
    add(4'h5, 0, 0, 15'h0,          "ld_exec");
    add(4'h5, 0, 0, E_REQ | E_AS,   "ld_mem_w1");
    add(4'h5, 0, 0, E_REQ | E_AS,   "ld_mem_w2");
    add(4'h5, 0, 0, E_REQ | E_AS,   "ld_mem_w3");
    add(4'h5, 0, 1, E_REQ | E_AS,   "ld_mem_rdy");
    add(4'h5, 0, 0, E_RW | E_WBS,   "ld_wb");
    add(4'h7, 1, 1, E_FOK,          "beq1_fetch");
    add(4'h7, 1, 0, 15'h0,          "beq1_dec");
    add(4'h7, 1, 0, E_SUB | E_PCW | E_PCS,
        "beq1_exec");
    add(4'h7, 0, 1, E_FOK,          "beq0_fetch");
    add(4'h7, 0, 0, 15'h0,          "beq0_dec");
    add(4'h7, 0, 0, E_SUB,          "beq0_exec");
    add(4'hB, 0, 1, E_FOK,          "ill_fetch");
    add(4'hB, 0, 1, E_ILL,          "ill_dec");
    add(4'h6, 0, 1, E_FOK,          "st_fetch");
    add(4'h6, 0, 0, 15'h0,          "st_dec");
    add(4'h6, 0, 0, 15'h0,          "st_exec");
    add(4'h6, 0, 1, E_REQ | E_WE | E_AS,
        "st_mem");
    add(4'h8, 0, 1, E_FOK,          "jmp_fetch");
    add(4'h8, 0, 0, 15'h0,          "jmp_dec");
    add(4'h8, 0, 0, E_PCW | E_PCS,  "jmp_exec");
    add(4'h3, 0, 0, E_REQ,          "or_fetch_w");
    add(4'h3, 0, 1, E_FOK,          "or_fetch");
    add(4'h3, 0, 0, 15'h0,          "or_dec");
    add(4'h3, 0, 0, E_OR,           "or_exec");
    add(4'h3, 0, 0, E_RW | E_OR,    "or_wb");

    #2;
    check("reset_state", outs, 15'h0000);
    @(posedge clock);
    #1;
    reset_n = 1'b1;

    foreach (tbl[i])
      cyc(tbl[i].op, tbl[i].z, tbl[i].rdy,
          tbl[i].exp, tbl[i].nm);

    for (int i = 0; i < 15; i++)
      cyc(4'h0, 0, 0, E_REQ, "wd_stall");
    cyc(4'h0, 0, 0, E_HLT | E_BF, "wd_fault");
    cyc(4'h0, 0, 1, E_HLT | E_BF, "wd_fault_hold");
    async_reset("rst_after_fault");

    for (int i = 0; i < 14; i++)
      cyc(4'hF, 0, 0, E_REQ, "wd_edge_stall");
    cyc(4'hF, 0, 1, E_FOK, "wd_edge_rdy");
    cyc(4'hF, 0, 0, 15'h0, "halt_dec");
    cyc(4'hF, 0, 0, E_HLT, "halt_state");
    cyc(4'hF, 0, 1, E_HLT, "halt_ignore_rdy");
    async_reset("rst_in_halt");

    cyc(4'h4, 0, 0, E_REQ, "resume_w1");
    cyc(4'h4, 0, 0, E_REQ, "resume_w2");
    async_reset("rst_mid_stall");
    cyc(4'h4, 0, 0, E_REQ, "post_rst_fetch");
    cyc(4'h4, 0, 1, E_FOK, "post_rst_rdy");
    cyc(4'h4, 0, 0, 15'h0, "post_rst_dec");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
